// File: rtl/ft245_chan_arb_pkg.sv
// Shared types and header-field layout for the FT245 channel multiplexer.
package ft245_chan_arb_pkg;

  // Largest channel count the 4-bit header channel field can address
  localparam int MAX_NCH = 16;

  // Header byte layout: {ch, len}
  localparam int HDR_CH_MSB  = 7;
  localparam int HDR_CH_LSB  = 4;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;

  localparam int CH_W  = HDR_CH_MSB - HDR_CH_LSB + 1;
  localparam int LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_DATA = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_DATA = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_t;

  // Build a frame header byte from its channel and length fields
  function automatic logic [7:0] make_hdr(input logic [CH_W-1:0] ch, input logic [LEN_W-1:0] len);
    return {ch, len};
  endfunction

endpackage

// File: rtl/ft245_chan_arb_arbiter.sv
// Per-frame TX channel arbiter.
// FT245_CHAN_ARB_RR_EN defined : round-robin, search starts after the last winner.
// FT245_CHAN_ARB_RR_EN undefined: fixed priority, lowest index wins, no state.
module chan_rr_arbiter
  import ft245_chan_arb_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  i_req,
  input  logic            i_grant_en,
  output logic [NCH-1:0]  o_grant,
  output logic [CH_W-1:0] o_idx
);

  logic w_found;

`ifdef FT245_CHAN_ARB_RR_EN

  logic [CH_W-1:0] r_ptr;

  // Rotating search: lowest requester at or above r_ptr, else lowest below it
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && i_req[i] && (CH_W'(i) >= r_ptr)) begin
        o_grant[i] = 1'b1;
        o_idx      = CH_W'(i);
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && i_req[i] && (CH_W'(i) < r_ptr)) begin
        o_grant[i] = 1'b1;
        o_idx      = CH_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1 (mod NCH) only when a grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_grant_en && w_found) begin
      r_ptr <= (o_idx == CH_W'(NCH - 1)) ? '0 : o_idx + CH_W'(1);
    end
  end

`else

  // Fixed priority: lowest requesting index wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_idx      = CH_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Clock, reset and grant-enable only matter to the rotating pointer
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, i_grant_en};

`endif

endmodule

// File: rtl/ft245_chan_arb.sv
// Multiplexes NCH client byte channels onto one FT245 byte stream using a
// one-byte {ch, len} header per frame. TX emits len=0 frames; RX accepts any len
// and demultiplexes by header. All handshakes are seq/ack toggle pairs.
// FT245_CHAN_ARB_RR_EN selects round-robin TX arbitration (default: fixed priority).
module ft245_chan_arb
  import ft245_chan_arb_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH*8-1:0] chan_tx_data,
  input  logic [NCH-1:0]   chan_tx_seq,
  output logic [NCH-1:0]   chan_tx_ack,
  output logic [7:0]       chan_rx_data,
  output logic [NCH-1:0]   chan_rx_seq,
  input  logic [NCH-1:0]   chan_rx_ack,
  output logic [7:0]       link_tx_data,
  output logic             link_tx_seq,
  input  logic             link_tx_ack,
  input  logic [7:0]       link_rx_data,
  input  logic             link_rx_seq,
  output logic             link_rx_ack,
  output logic             err_chan
);

  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("ft245_chan_arb: NCH must be in 1..16");
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t       r_tx_state, w_tx_next;
  logic [NCH-1:0]  r_chan_tx_ack, w_chan_tx_ack_nxt;
  logic [CH_W-1:0] r_tx_ch, w_tx_ch_nxt;
  logic [7:0]      r_tx_byte, w_tx_byte_nxt;
  logic [7:0]      r_link_tx_data, w_link_tx_data_nxt;
  logic            r_link_tx_seq, w_link_tx_seq_nxt;

  logic [NCH-1:0]  w_tx_pend;
  logic [NCH-1:0]  w_tx_grant;
  logic [CH_W-1:0] w_tx_idx;
  logic [7:0]      w_tx_sel_byte;
  logic            w_link_tx_free;

  assign w_tx_pend      = chan_tx_seq ^ r_chan_tx_ack;
  assign w_link_tx_free = (link_tx_ack == r_link_tx_seq);

  chan_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk        (clk),
    .rst_n      (reset),
    .i_req      (w_tx_pend),
    .i_grant_en (r_tx_state == TX_IDLE),
    .o_grant    (w_tx_grant),
    .o_idx      (w_tx_idx)
  );

  // One-hot byte select of the winning channel's TX data
  always_comb begin
    w_tx_sel_byte = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_tx_grant[i]) w_tx_sel_byte = w_tx_sel_byte | chan_tx_data[i*8 +: 8];
    end
  end

  // TX state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state     <= TX_IDLE;
      r_chan_tx_ack  <= '0;
      r_tx_ch        <= '0;
      r_tx_byte      <= '0;
      r_link_tx_data <= '0;
      r_link_tx_seq  <= 1'b0;
    end else begin
      r_tx_state     <= w_tx_next;
      r_chan_tx_ack  <= w_chan_tx_ack_nxt;
      r_tx_ch        <= w_tx_ch_nxt;
      r_tx_byte      <= w_tx_byte_nxt;
      r_link_tx_data <= w_link_tx_data_nxt;
      r_link_tx_seq  <= w_link_tx_seq_nxt;
    end
  end

  // TX next state: grant, then header, then data, each gated by a free link
  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE: if (|w_tx_pend)     w_tx_next = TX_HDR;
      TX_HDR:  if (w_link_tx_free) w_tx_next = TX_DATA;
      TX_DATA: if (w_link_tx_free) w_tx_next = TX_IDLE;
      default:                     w_tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: latch winner and ack it, then push header and byte to the link
  always_comb begin
    w_chan_tx_ack_nxt  = r_chan_tx_ack;
    w_tx_ch_nxt        = r_tx_ch;
    w_tx_byte_nxt      = r_tx_byte;
    w_link_tx_data_nxt = r_link_tx_data;
    w_link_tx_seq_nxt  = r_link_tx_seq;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (|w_tx_pend) begin
          w_tx_ch_nxt       = w_tx_idx;
          w_tx_byte_nxt     = w_tx_sel_byte;
          w_chan_tx_ack_nxt = (r_chan_tx_ack & ~w_tx_grant) | (chan_tx_seq & w_tx_grant);
        end
      end
      TX_HDR: begin
        if (w_link_tx_free) begin
          w_link_tx_data_nxt = make_hdr(r_tx_ch, LEN_W'(0));
          w_link_tx_seq_nxt  = ~r_link_tx_seq;
        end
      end
      TX_DATA: begin
        if (w_link_tx_free) begin
          w_link_tx_data_nxt = r_tx_byte;
          w_link_tx_seq_nxt  = ~r_link_tx_seq;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  rx_state_t        r_rx_state, w_rx_next;
  logic [CH_W-1:0]  r_rx_ch, w_rx_ch_nxt;
  logic [LEN_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [7:0]       r_chan_rx_data, w_chan_rx_data_nxt;
  logic [NCH-1:0]   r_chan_rx_seq, w_chan_rx_seq_nxt;
  logic             r_link_rx_ack, w_link_rx_ack_nxt;
  logic             r_err_chan, w_err_chan_nxt;

  logic             w_link_rx_pend;
  logic             w_rx_bad_ch;
  logic             w_rx_last;
  logic [NCH-1:0]   w_rx_sel;
  logic             w_rx_client_done;

  assign w_link_rx_pend   = link_rx_seq ^ r_link_rx_ack;
  assign w_rx_bad_ch      = ({1'b0, r_rx_ch} >= (CH_W + 1)'(NCH));
  assign w_rx_last        = (r_rx_cnt == '0);
  assign w_rx_client_done = |(w_rx_sel & ~(chan_rx_ack ^ r_chan_rx_seq));

  // Decode the latched header channel to a one-hot client select
  always_comb begin
    w_rx_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      w_rx_sel[i] = (r_rx_ch == CH_W'(i));
    end
  end

  // RX state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state     <= RX_HDR;
      r_rx_ch        <= '0;
      r_rx_cnt       <= '0;
      r_chan_rx_data <= '0;
      r_chan_rx_seq  <= '0;
      r_link_rx_ack  <= 1'b0;
      r_err_chan     <= 1'b0;
    end else begin
      r_rx_state     <= w_rx_next;
      r_rx_ch        <= w_rx_ch_nxt;
      r_rx_cnt       <= w_rx_cnt_nxt;
      r_chan_rx_data <= w_chan_rx_data_nxt;
      r_chan_rx_seq  <= w_chan_rx_seq_nxt;
      r_link_rx_ack  <= w_link_rx_ack_nxt;
      r_err_chan     <= w_err_chan_nxt;
    end
  end

  // RX next state: header, then one data byte at a time, waiting on the client
  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      RX_HDR: if (w_link_rx_pend) w_rx_next = RX_DATA;
      RX_DATA: begin
        if (w_link_rx_pend) begin
          if (!w_rx_bad_ch)    w_rx_next = RX_WAIT;
          else if (w_rx_last)  w_rx_next = RX_HDR;
        end
      end
      RX_WAIT: if (w_rx_client_done) w_rx_next = w_rx_last ? RX_HDR : RX_DATA;
      default: w_rx_next = RX_HDR;
    endcase
  end

  // RX outputs: consume link bytes, hand valid ones to the client, flag bad ones
  always_comb begin
    w_rx_ch_nxt        = r_rx_ch;
    w_rx_cnt_nxt       = r_rx_cnt;
    w_chan_rx_data_nxt = r_chan_rx_data;
    w_chan_rx_seq_nxt  = r_chan_rx_seq;
    w_link_rx_ack_nxt  = r_link_rx_ack;
    w_err_chan_nxt     = 1'b0;
    unique case (r_rx_state)
      RX_HDR: begin
        if (w_link_rx_pend) begin
          w_rx_ch_nxt       = link_rx_data[HDR_CH_MSB:HDR_CH_LSB];
          w_rx_cnt_nxt      = link_rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
          w_link_rx_ack_nxt = link_rx_seq;
        end
      end
      RX_DATA: begin
        if (w_link_rx_pend) begin
          w_link_rx_ack_nxt = link_rx_seq;
          if (w_rx_bad_ch) begin
            w_err_chan_nxt = 1'b1;
            if (!w_rx_last) w_rx_cnt_nxt = r_rx_cnt - LEN_W'(1);
          end else begin
            w_chan_rx_data_nxt = link_rx_data;
            w_chan_rx_seq_nxt  = r_chan_rx_seq ^ w_rx_sel;
          end
        end
      end
      RX_WAIT: begin
        if (w_rx_client_done && !w_rx_last) w_rx_cnt_nxt = r_rx_cnt - LEN_W'(1);
      end
      default: ;
    endcase
  end

  assign chan_tx_ack  = r_chan_tx_ack;
  assign link_tx_data = r_link_tx_data;
  assign link_tx_seq  = r_link_tx_seq;
  assign chan_rx_data = r_chan_rx_data;
  assign chan_rx_seq  = r_chan_rx_seq;
  assign link_rx_ack  = r_link_rx_ack;
  assign err_chan     = r_err_chan;

endmodule

// File: tb/tb_ft245_chan_arb.sv
// Self-checking bench for ft245_chan_arb (NCH=4). Link and client models run
// on the falling edge; expected link bytes and client bytes live in queues.
module tb_ft245_chan_arb;

  localparam int NCH = 4;

  logic             clk;
  logic             reset;
  logic [NCH*8-1:0] chan_tx_data;
  logic [NCH-1:0]   chan_tx_seq;
  logic [NCH-1:0]   chan_tx_ack;
  logic [7:0]       chan_rx_data;
  logic [NCH-1:0]   chan_rx_seq;
  logic [NCH-1:0]   chan_rx_ack;
  logic [7:0]       link_tx_data;
  logic             link_tx_seq;
  logic             link_tx_ack;
  logic [7:0]       link_rx_data;
  logic             link_rx_seq;
  logic             link_rx_ack;
  logic             err_chan;

  ft245_chan_arb #(.NCH(NCH)) dut (
    .clk          (clk),
    .reset        (reset),
    .chan_tx_data (chan_tx_data),
    .chan_tx_seq  (chan_tx_seq),
    .chan_tx_ack  (chan_tx_ack),
    .chan_rx_data (chan_rx_data),
    .chan_rx_seq  (chan_rx_seq),
    .chan_rx_ack  (chan_rx_ack),
    .link_tx_data (link_tx_data),
    .link_tx_seq  (link_tx_seq),
    .link_tx_ack  (link_tx_ack),
    .link_rx_data (link_rx_data),
    .link_rx_seq  (link_rx_seq),
    .link_rx_ack  (link_rx_ack),
    .err_chan     (err_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic [7:0] exp_hdr;
  } tx_vec_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } rx_exp_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]     tx_q[$];
  rx_exp_t        rx_q[$];
  int             tx_ack_delay = 0;
  int             rx_delay[NCH];
  int             err_seen = 0;
  logic [NCH-1:0] exp_tx_ack;
  logic [NCH-1:0] exp_rx_seq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] out_snapshot();
    return 32'({chan_tx_ack, chan_rx_seq, chan_rx_data, link_tx_data,
                link_tx_seq, link_rx_ack, err_chan});
  endfunction

  // Link TX side: compare each new link byte with the scoreboard, ack after a delay
  initial begin : tx_link_model
    int   wait_cnt;
    bit   seen;
    logic [7:0] exp;
    link_tx_ack = 1'b0;
    seen = 0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        link_tx_ack = 1'b0;
        seen = 0;
      end else if (link_tx_seq != link_tx_ack) begin
        if (!seen) begin
          seen = 1;
          wait_cnt = tx_ack_delay;
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_link_unexpected: got 0x%0h expected no byte", link_tx_data);
          end else begin
            exp = tx_q.pop_front();
            check("tx_link_byte", {24'h0, link_tx_data}, {24'h0, exp});
          end
        end
        if (wait_cnt == 0) begin
          link_tx_ack = link_tx_seq;
          seen = 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // RX clients: compare each delivered byte with the scoreboard, ack after a per-channel delay
  initial begin : rx_client_model
    bit      seen[NCH];
    int      cnt[NCH];
    rx_exp_t e;
    chan_rx_ack = '0;
    for (int i = 0; i < NCH; i++) begin
      seen[i] = 0;
      cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (!reset) begin
          chan_rx_ack[i] = 1'b0;
          seen[i] = 0;
        end else if (chan_rx_seq[i] != chan_rx_ack[i]) begin
          if (!seen[i]) begin
            seen[i] = 1;
            cnt[i] = rx_delay[i];
            if (rx_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rx_unexpected: ch %0d got 0x%0h expected no byte", i, chan_rx_data);
            end else begin
              e = rx_q.pop_front();
              check("rx_client_ch", i, e.ch);
              check("rx_client_data", {24'h0, chan_rx_data}, {24'h0, e.data});
            end
          end
          if (cnt[i] == 0) begin
            chan_rx_ack[i] = chan_rx_seq[i];
            seen[i] = 0;
          end else begin
            cnt[i]--;
          end
        end
      end
    end
  end

  // Count cycles with err_chan high
  initial begin : err_monitor
    forever begin
      @(negedge clk);
      if (err_chan) err_seen++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_tx_drain(input string name, input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || link_tx_seq != link_tx_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_q.size() != 0 || link_tx_seq != link_tx_ack) timeout_fail(name);
  endtask

  task automatic wait_rx_drain(input string name, input int budget);
    int n = 0;
    while ((rx_q.size() != 0 || chan_rx_seq != chan_rx_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rx_q.size() != 0 || chan_rx_seq != chan_rx_ack) timeout_fail(name);
  endtask

  task automatic rx_wait_ack(input string name, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (link_rx_ack != link_rx_seq && lat < budget);
    if (link_rx_ack != link_rx_seq) timeout_fail(name);
  endtask

  task automatic rx_send(input logic [7:0] b, input string name, output int lat);
    link_rx_data = b;
    link_rx_seq  = ~link_rx_seq;
    rx_wait_ack(name, 60, lat);
  endtask

  initial begin : main
    tx_vec_t    vecs[4];
    int         lat;
    logic       old_ack;
    logic [7:0] d0, d1, d3, d0b;

    reset        = 1'b0;
    chan_tx_data = '0;
    chan_tx_seq  = '0;
    link_rx_data = '0;
    link_rx_seq  = 1'b0;
    exp_tx_ack   = '0;
    exp_rx_seq   = '0;
    for (int i = 0; i < NCH; i++) rx_delay[i] = 0;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_snapshot(), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // ---- table-driven single TX frames
    vecs[0] = '{2, 8'h5A, 8'h20};
    vecs[1] = '{0, 8'h00, 8'h00};
    vecs[2] = '{3, 8'hFF, 8'h30};
    vecs[3] = '{1, 8'hA5, 8'h10};
    for (int v = 0; v < 4; v++) begin
      chan_tx_data[vecs[v].ch*8 +: 8] = vecs[v].data;
      chan_tx_seq[vecs[v].ch] = ~chan_tx_seq[vecs[v].ch];
      exp_tx_ack[vecs[v].ch]  = chan_tx_seq[vecs[v].ch];
      tx_q.push_back(vecs[v].exp_hdr);
      tx_q.push_back(vecs[v].data);
      @(negedge clk);
      check($sformatf("tx_ack_1edge_v%0d", v), 32'(chan_tx_ack), 32'(exp_tx_ack));
      wait_tx_drain($sformatf("tx_vec%0d", v), 50);
    end

    // ---- concurrent requests on ch0, ch1, ch3: plain round
    d0 = 8'hC0; d1 = 8'hC1; d3 = 8'hC3;
    chan_tx_data[7:0] = d0; chan_tx_data[15:8] = d1; chan_tx_data[31:24] = d3;
    tx_q.push_back(8'h00); tx_q.push_back(d0);
    tx_q.push_back(8'h10); tx_q.push_back(d1);
    tx_q.push_back(8'h30); tx_q.push_back(d3);
    chan_tx_seq = chan_tx_seq ^ 4'b1011;
    exp_tx_ack  = chan_tx_seq;
    wait_tx_drain("tx_conc_round1", 100);
    check("tx_conc_round1_acks", 32'(chan_tx_ack), 32'(exp_tx_ack));

    // ---- second round: ch0 re-requests right after its first grant
    d0 = 8'hD0; d1 = 8'hD1; d3 = 8'hD3; d0b = 8'hE0;
    chan_tx_data[7:0] = d0; chan_tx_data[15:8] = d1; chan_tx_data[31:24] = d3;
`ifdef FT245_CHAN_ARB_RR_EN
    tx_q.push_back(8'h00); tx_q.push_back(d0);
    tx_q.push_back(8'h10); tx_q.push_back(d1);
    tx_q.push_back(8'h30); tx_q.push_back(d3);
    tx_q.push_back(8'h00); tx_q.push_back(d0b);
`else
    tx_q.push_back(8'h00); tx_q.push_back(d0);
    tx_q.push_back(8'h00); tx_q.push_back(d0b);
    tx_q.push_back(8'h10); tx_q.push_back(d1);
    tx_q.push_back(8'h30); tx_q.push_back(d3);
`endif
    chan_tx_seq = chan_tx_seq ^ 4'b1011;
    @(negedge clk);
    exp_tx_ack[0] = chan_tx_seq[0];
    check("tx_conc_first_grant", 32'(chan_tx_ack), 32'(exp_tx_ack));
    chan_tx_data[7:0] = d0b;
    chan_tx_seq[0] = ~chan_tx_seq[0];
    exp_tx_ack = chan_tx_seq;
    wait_tx_drain("tx_conc_round2", 150);
    check("tx_conc_round2_acks", 32'(chan_tx_ack), 32'(exp_tx_ack));

    // ---- RX burst for ch1 with a slow client: header 0x13 carries four bytes
    rx_delay[1] = 6;
    rx_send(8'h13, "rx_burst_hdr", lat);
    check("rx_hdr_latency", lat, 1);
    rx_q.push_back('{1, 8'hAA});
    rx_send(8'hAA, "rx_burst_aa", lat);
    exp_rx_seq[1] = ~exp_rx_seq[1];
    check("rx_data_latency", lat, 1);
    check("rx_aa_seq", 32'(chan_rx_seq), 32'(exp_rx_seq));
    rx_q.push_back('{1, 8'hBB});
    old_ack = link_rx_seq;
    link_rx_data = 8'hBB;
    link_rx_seq  = ~link_rx_seq;
    repeat (3) @(negedge clk);
    check("rx_bb_ack_withheld", 32'(link_rx_ack), 32'(old_ack));
    rx_wait_ack("rx_burst_bb", 60, lat);
    exp_rx_seq[1] = ~exp_rx_seq[1];
    rx_delay[1] = 0;
    rx_q.push_back('{1, 8'hCC});
    rx_send(8'hCC, "rx_burst_cc", lat);
    exp_rx_seq[1] = ~exp_rx_seq[1];
    rx_q.push_back('{1, 8'hDD});
    rx_send(8'hDD, "rx_burst_dd", lat);
    exp_rx_seq[1] = ~exp_rx_seq[1];
    wait_rx_drain("rx_burst_drain", 60);
    check("rx_burst_seq", 32'(chan_rx_seq), 32'(exp_rx_seq));

    // ---- invalid channel 7 (two bytes discarded), then a valid ch0 frame
    err_seen = 0;
    rx_send(8'h71, "rx_bad_hdr", lat);
    rx_send(8'h11, "rx_bad_b0", lat);
    check("rx_discard_latency", lat, 1);
    rx_send(8'h22, "rx_bad_b1", lat);
    @(negedge clk);
    check("rx_err_pulses", err_seen, 2);
    check("rx_bad_no_seq", 32'(chan_rx_seq), 32'(exp_rx_seq));
    rx_q.push_back('{0, 8'h33});
    rx_send(8'h00, "rx_ch0_hdr", lat);
    rx_send(8'h33, "rx_ch0_b0", lat);
    exp_rx_seq[0] = ~exp_rx_seq[0];
    wait_rx_drain("rx_ch0_drain", 60);
    check("rx_after_bad_seq", 32'(chan_rx_seq), 32'(exp_rx_seq));
    check("rx_err_total", err_seen, 2);

    // ---- simultaneous TX on ch0 and RX frame for ch3
    rx_q.push_back('{3, 8'h77});
    tx_q.push_back(8'h00); tx_q.push_back(8'h5C);
    chan_tx_data[7:0] = 8'h5C;
    chan_tx_seq[0] = ~chan_tx_seq[0];
    exp_tx_ack[0]  = chan_tx_seq[0];
    link_rx_data = 8'h30;
    link_rx_seq  = ~link_rx_seq;
    fork
      begin
        int l1, l2;
        rx_wait_ack("simul_rx_hdr", 60, l1);
        rx_send(8'h77, "simul_rx_data", l2);
      end
      wait_tx_drain("simul_tx", 60);
    join
    exp_rx_seq[3] = ~exp_rx_seq[3];
    wait_rx_drain("simul_rx_drain", 60);
    check("simul_tx_ack", 32'(chan_tx_ack), 32'(exp_tx_ack));
    check("simul_rx_seq", 32'(chan_rx_seq), 32'(exp_rx_seq));

    // ---- reset while the TX FSM waits in TX_DATA
    tx_ack_delay = 20;
    chan_tx_data[15:8] = 8'h42;
    chan_tx_seq[1] = ~chan_tx_seq[1];
    tx_q.push_back(8'h10); tx_q.push_back(8'h42);
    begin
      int n = 0;
      while (tx_q.size() != 1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (tx_q.size() != 1) timeout_fail("rst_wait_hdr");
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outputs", out_snapshot(), 32'h0);
    chan_tx_seq  = '0;
    chan_tx_data = '0;
    link_rx_seq  = 1'b0;
    link_rx_data = '0;
    tx_q.delete();
    rx_q.delete();
    exp_tx_ack   = '0;
    exp_rx_seq   = '0;
    tx_ack_delay = 0;
    repeat (2) @(negedge clk);
    check("rst_held_outputs", out_snapshot(), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chan_tx_data[23:16] = 8'h99;
    chan_tx_seq[2] = 1'b1;
    exp_tx_ack[2]  = 1'b1;
    tx_q.push_back(8'h20); tx_q.push_back(8'h99);
    @(negedge clk);
    check("post_rst_ack", 32'(chan_tx_ack), 32'(exp_tx_ack));
    wait_tx_drain("post_rst_tx", 50);

    repeat (3) @(negedge clk);
    check("tx_scoreboard_empty", tx_q.size(), 0);
    check("rx_scoreboard_empty", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
